// File: rtl/video_instr_pkg.sv
// Shared opcode constants and decoded-entry layout for the video instruction path.
package video_instr_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned ILL_W = 8;

  localparam logic [OPC_W-1:0] OP_WBR     = 4'h0;
  localparam logic [OPC_W-1:0] OP_WSM     = 4'h1;
  localparam logic [OPC_W-1:0] OP_CHK     = 4'h2;
  localparam logic [OPC_W-1:0] OP_NOP     = 4'h3;
  localparam logic [OPC_W-1:0] OP_DEFAULT = 4'hF;

  localparam logic [ILL_W-1:0] ILL_MAX = 8'hFF;

  // Fixed-width control part of a decoded entry; address and data follow it.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic             check_screen;
  } entry_ctrl_t;

  localparam int unsigned ENTRY_CTRL_W = $bits(entry_ctrl_t);

  // Total stored width of one decoded entry.
  function automatic int unsigned entry_w(input int unsigned addr_w, input int unsigned data_w);
    return ENTRY_CTRL_W + addr_w + data_w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with registered full/empty/count derived from extra-bit pointers.
module instr_fifo #(
  parameter int unsigned WIDTH = 51,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   wr_nxt;
  logic [PTR_W:0]   rd_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Qualify requests against the registered status so full/empty misuse is harmless.
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    wr_nxt  = wr_ptr + {{PTR_W{1'b0}}, push_ok};
    rd_nxt  = rd_ptr + {{PTR_W{1'b0}}, pop_ok};
  end

  // Pointers and status registers; status is computed from the next pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= wr_nxt - rd_nxt;
      full   <= (wr_nxt[PTR_W] != rd_nxt[PTR_W]) &&
                (wr_nxt[PTR_W-1:0] == rd_nxt[PTR_W-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instr_decode_fifo.sv
// Host custom-instruction decoder with a queued output toward the video control unit.
module instr_decode_fifo
  import video_instr_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            dataA,
  input  logic [DATA_W-1:0]      dataB,
  output logic                   in_full,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [OPC_W-1:0]       out_opcode,
  output logic [ADDR_W-1:0]      out_register,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_check_screen,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [ILL_W-1:0]       illegal_count,
  output logic                   overflow
);

  localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W);

  entry_ctrl_t        dec_ctrl;
  logic [ADDR_W-1:0]  dec_reg;
  logic [DATA_W-1:0]  dec_data;
  logic               dec_push;
  logic               dec_illegal;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  entry_ctrl_t        head_ctrl;
  logic               unused_dataa;

  // Upper instruction bits carry no field in this encoding.
  assign unused_dataa = ^dataA[31:ADDR_W+4];

  // Combinational decode of the instruction currently presented by the host.
  always_comb begin
    dec_ctrl.opcode       = OP_DEFAULT;
    dec_ctrl.check_screen = 1'b0;
    dec_reg               = '0;
    dec_data              = '0;
    dec_push              = 1'b0;
    dec_illegal           = 1'b0;
    case (dataA[3:0])
      OP_WBR: begin
        dec_ctrl.opcode = OP_WBR;
        dec_reg         = ADDR_W'(dataA[REG_W+3:4]);
        dec_data        = dataB;
        dec_push        = 1'b1;
      end
      OP_WSM: begin
        dec_ctrl.opcode = OP_WSM;
        dec_reg         = dataA[ADDR_W+3:4];
        dec_data        = dataB;
        dec_push        = 1'b1;
      end
      OP_CHK: begin
        dec_ctrl.check_screen = 1'b1;
        dec_push              = 1'b1;
      end
      OP_NOP: ;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign push = in_valid && !in_full && dec_push;
  assign pop  = out_valid && out_ack;

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({dec_ctrl, dec_reg, dec_data}),
    .rdata (head),
    .full  (in_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign head_ctrl = entry_ctrl_t'(head[ENTRY_W-1 -: ENTRY_CTRL_W]);

  // Present the head entry, or idle defaults when nothing is queued.
  always_comb begin
    out_opcode       = OP_DEFAULT;
    out_register     = '0;
    out_data         = '0;
    out_check_screen = 1'b0;
    if (out_valid) begin
      out_opcode       = head_ctrl.opcode;
      out_register     = head[DATA_W +: ADDR_W];
      out_data         = head[DATA_W-1:0];
      out_check_screen = head_ctrl.check_screen;
    end
  end

  // Saturating illegal-opcode counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_count <= '0;
      overflow      <= 1'b0;
    end else if (in_valid) begin
      if (in_full) begin
        overflow <= 1'b1;
      end else if (dec_illegal && (illegal_count != ILL_MAX)) begin
        illegal_count <= illegal_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode_fifo.sv
// Scoreboard bench for instr_decode_fifo: queue-level model, negedge monitor.
module tb_instr_decode_fifo;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [31:0]       dataA;
  logic [DATA_W-1:0] dataB;
  logic              out_ack;
  logic              in_full;
  logic              out_valid;
  logic [3:0]        out_opcode;
  logic [ADDR_W-1:0] out_register;
  logic [DATA_W-1:0] out_data;
  logic              out_check_screen;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        illegal_count;
  logic              overflow;

  instr_decode_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .dataA            (dataA),
    .dataB            (dataB),
    .in_full          (in_full),
    .out_valid        (out_valid),
    .out_ack          (out_ack),
    .out_opcode       (out_opcode),
    .out_register     (out_register),
    .out_data         (out_data),
    .out_check_screen (out_check_screen),
    .fifo_count       (fifo_count),
    .illegal_count    (illegal_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        op;
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] d;
    logic              chk;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt;
  int   m_ill;
  bit   m_ovf;
  bit   mon_en;
  int   tests;
  int   fails;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference decode from the opcode rules; returns 1 when the entry is queued.
  function automatic bit model_decode(input logic [31:0] a, input logic [DATA_W-1:0] b, output exp_t e);
    longint op    = longint'(a) % 16;
    longint field = longint'(a) / 16;
    e.op  = 4'hF;
    e.rg  = '0;
    e.d   = '0;
    e.chk = 1'b0;
    if (op == 0) begin
      e.op = 4'h0;
      e.rg = ADDR_W'(field % (64'd1 << REG_W));
      e.d  = b;
      return 1'b1;
    end
    if (op == 1) begin
      e.op = 4'h1;
      e.rg = ADDR_W'(field % (64'd1 << ADDR_W));
      e.d  = b;
      return 1'b1;
    end
    if (op == 2) begin
      e.chk = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model: track queued entries, occupancy and counters at each rising edge.
  initial begin
    m_cnt = 0;
    m_ill = 0;
    m_ovf = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        m_cnt = 0;
        m_ill = 0;
        m_ovf = 1'b0;
      end else begin
        exp_t e;
        int   acc;
        int   pp;
        acc = 0;
        pp  = (out_ack && m_cnt > 0) ? 1 : 0;
        if (in_valid) begin
          if (m_cnt == DEPTH) begin
            m_ovf = 1'b1;
          end else if (model_decode(dataA, dataB, e)) begin
            exp_q.push_back(e);
            acc = 1;
          end else if (dataA[3:0] >= 4'd4 && m_ill < 255) begin
            m_ill++;
          end
        end
        m_cnt = m_cnt + acc - pp;
      end
    end
  end

  // Monitor: compare status every cycle and the head entry whenever it is valid.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("fifo_count", 64'(fifo_count), 64'(m_cnt));
        chk("in_full", 64'(in_full), 64'(m_cnt == DEPTH));
        chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
        chk("illegal_count", 64'(illegal_count), 64'(m_ill));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("head_present", 64'(out_valid), 64'd0);
          end else begin
            chk("head_opcode", 64'(out_opcode), 64'(exp_q[0].op));
            chk("head_register", 64'(out_register), 64'(exp_q[0].rg));
            chk("head_data", 64'(out_data), 64'(exp_q[0].d));
            chk("head_check_screen", 64'(out_check_screen), 64'(exp_q[0].chk));
            if (out_ack) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_opcode", 64'(out_opcode), 64'hF);
          chk("idle_register", 64'(out_register), 64'd0);
          chk("idle_data", 64'(out_data), 64'd0);
          chk("idle_check_screen", 64'(out_check_screen), 64'd0);
        end
      end
    end
  end

  // Hard stop if the run ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [DATA_W-1:0] b, input bit ack);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = v;
    dataA    = a;
    dataB    = b;
    out_ack  = ack;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 32'h0, '0, 1'b1);
    idle(1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    dataA    = 32'h0;
    dataB    = DATA_W'($urandom);
    out_ack  = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    out_ack  = 1'b0;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    dataA    = '0;
    dataB    = '0;
    out_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_fifo_count", 64'(fifo_count), 64'd0);

    // Single WBR entry appears the cycle after the push.
    drive(1'b1, 32'h0000_01A0, 32'h0012_0034, 1'b0);
    idle(1);
    @(negedge clk);
    chk("wbr_valid", 64'(out_valid), 64'd1);
    chk("wbr_opcode", 64'(out_opcode), 64'd0);
    chk("wbr_register", 64'(out_register), 64'd26);
    chk("wbr_data", 64'(out_data), 64'h0012_0034);
    drain();

    // WSM followed by check-screen, delivered in order.
    drive(1'b1, 32'h0002_ABC1, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 32'h0000_0002, 32'h1234_5678, 1'b0);
    idle(1);
    @(negedge clk);
    chk("two_count", 64'(fifo_count), 64'd2);
    chk("wsm_register", 64'(out_register), 64'h2ABC);
    drive(1'b0, 32'h0, '0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("chk_opcode", 64'(out_opcode), 64'hF);
    chk("chk_flag", 64'(out_check_screen), 64'd1);
    chk("chk_data", 64'(out_data), 64'd0);
    drain();

    // NOP and illegal opcodes are not queued.
    drive(1'b1, 32'h0000_0013, 32'h1, 1'b0);
    drive(1'b1, 32'h0000_0025, 32'h2, 1'b0);
    drive(1'b1, 32'h0000_003F, 32'h3, 1'b0);
    idle(1);
    @(negedge clk);
    chk("nop_ill_count", 64'(fifo_count), 64'd0);
    chk("illegal_two", 64'(illegal_count), 64'd2);
    for (int i = 0; i < 260; i++)
      drive(1'b1, {$urandom_range(0, 32'h0FFF_FFFF), 4'(4 + $urandom_range(0, 11))}, DATA_W'($urandom), 1'b0);
    idle(1);
    @(negedge clk);
    chk("illegal_sat", 64'(illegal_count), 64'd255);

    // Fill, overflow on the extra push, then drain in order.
    for (int i = 0; i <= DEPTH; i++)
      drive(1'b1, {20'h0, 8'(i), 4'h1}, DATA_W'($urandom), 1'b0);
    idle(1);
    @(negedge clk);
    chk("full_flag", 64'(in_full), 64'd1);
    chk("full_count", 64'(fifo_count), 64'(DEPTH));
    chk("overflow_set", 64'(overflow), 64'd1);
    drain();
    @(negedge clk);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Push while full with a simultaneous pop: push dropped, pop proceeds.
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, {20'h0, 8'(i + 16), 4'h0}, DATA_W'($urandom), 1'b0);
    drive(1'b1, 32'h0000_0071, 32'hFFFF_0000, 1'b1);
    idle(1);
    @(negedge clk);
    chk("full_pop_count", 64'(fifo_count), 64'(DEPTH - 1));
    drain();

    // Steady stream with one entry resident; pointers wrap repeatedly.
    drive(1'b1, 32'h0000_0010, 32'hA5A5_0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, {$urandom_range(0, 32'h0FFF_FFFF), 4'(i % 2)}, DATA_W'(i), 1'b1);
      if (i > 0) chk("stream_count", 64'(fifo_count), 64'd1);
    end
    drain();

    // Randomised mix of opcodes, valid and ack.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15));
      drive($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h0FFF_FFFF), op},
            DATA_W'($urandom), $urandom_range(0, 2) == 0);
    end
    drain();

    // Reset with entries queued empties everything in one cycle.
    for (int i = 0; i < 3; i++)
      drive(1'b1, {24'h0, 4'(i), 4'h0}, DATA_W'($urandom), 1'b0);
    drive(1'b1, 32'h0000_0009, 32'h0, 1'b0);
    do_reset();
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_illegal", 64'(illegal_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    idle(2);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
